activation_derivative: RTL and testbench

- Backward-pass counterpart of the forward activation LUT. Consumes the packed vector of sigmoid activations the LUT produced and computes the sigmoid derivative a*(1-a) for each element, in fixed point.
- Uses the same start/valid handshake as the LUT.
- Time-multiplexes one multiplier across all N elements, one element per cycle, so the result can feed the delta computation in the backprop datapath.

---
 rtl/activation_derivative.sv | 115 +++++++++++
 tb/tb_activation_derivative.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/activation_derivative.sv
// Sigmoid derivative a*(1-a) over a packed activation vector, one shared multiplier, one element per cycle.
// Optional build macro DERIV_ROUND_EN: round-half-up on the final shift instead of truncation.
module activation_derivative #(
   parameter int unsigned NUM_NEURONS = 6,
   parameter int unsigned ACT_WIDTH   = 9,
   parameter int unsigned ACT_FRAC    = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [NUM_NEURONS*ACT_WIDTH-1:0] activations,
   output logic [NUM_NEURONS*ACT_WIDTH-1:0] derivatives,
   output logic                             busy,
   output logic                             valid
);

   localparam int unsigned PROD_W = 2 * ACT_WIDTH;
   localparam int unsigned IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic [ACT_WIDTH-1:0] ONE  = ACT_WIDTH'(1) << ACT_FRAC;
   localparam logic [IDX_W-1:0]     LAST = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state, next_state;
   logic [ACT_WIDTH-1:0]   buffer [NUM_NEURONS];
   logic [IDX_W-1:0]       index;
   logic [PROD_W-1:0]      prod;
   logic                   load, mul_en, wr_en, done;
   logic [IDX_W-1:0]       wr_idx;
   logic [ACT_WIDTH-1:0]   a_cur, a_sat;
   logic [PROD_W-1:0]      prod_c;
   logic [ACT_WIDTH-1:0]   d_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (index == LAST) next_state = DRAIN;
         DRAIN:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Control decode: stage 2 trails stage 1 by one element
   always_comb begin
      load   = 1'b0;
      mul_en = 1'b0;
      wr_en  = 1'b0;
      wr_idx = '0;
      done   = 1'b0;
      case (state)
         IDLE: load = start;
         RUN: begin
            mul_en = 1'b1;
            wr_en  = (index != '0);
            wr_idx = index - IDX_W'(1);
         end
         DRAIN: begin
            wr_en  = 1'b1;
            wr_idx = index;
            done   = 1'b1;
         end
         default: ;
      endcase
   end

   // Stage 1 arithmetic: saturate to 1.0, then a*(1-a)
   always_comb begin
      a_cur  = buffer[index];
      a_sat  = (a_cur > ONE) ? ONE : a_cur;
      prod_c = PROD_W'(a_sat) * PROD_W'(ONE - a_sat);
   end

   // Stage 2 rescale back to ACT_FRAC fractional bits
`ifdef DERIV_ROUND_EN
   localparam logic [PROD_W-1:0] HALF = PROD_W'(1) << (ACT_FRAC - 1);
   always_comb d_c = ACT_WIDTH'((prod + HALF) >> ACT_FRAC);
`else
   always_comb d_c = ACT_WIDTH'(prod >> ACT_FRAC);
`endif

   // Input capture; the bus is free once start is accepted
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < int'(NUM_NEURONS); i++)
            buffer[i] <= activations[i*ACT_WIDTH +: ACT_WIDTH];
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index       <= '0;
         prod        <= '0;
         derivatives <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
      end else begin
         if (load) index <= '0;
         else if (mul_en && index != LAST) index <= index + IDX_W'(1);
         if (mul_en) prod <= prod_c;
         if (wr_en) derivatives[wr_idx*ACT_WIDTH +: ACT_WIDTH] <= d_c;
         busy  <= (next_state != IDLE);
         valid <= done;
      end
   end

endmodule

// File: tb/tb_activation_derivative.sv
// Randomized self-checking bench for activation_derivative against a per-element arithmetic model.
module tb_activation_derivative;

   localparam int unsigned N  = 6;
   localparam int unsigned W  = 9;
   localparam int unsigned F  = 8;
   localparam int unsigned VW = N * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [VW-1:0] activations;
   logic [VW-1:0] derivatives;
   logic          busy;
   logic          valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   activation_derivative #(.NUM_NEURONS(N), .ACT_WIDTH(W), .ACT_FRAC(F)) dut (
      .clk(clk), .rst(rst), .start(start), .activations(activations),
      .derivatives(derivatives), .busy(busy), .valid(valid)
   );

   function automatic int model(int a);
      int s, p;
      s = (a > (1 << F)) ? (1 << F) : a;
      p = s * ((1 << F) - s);
`ifdef DERIV_ROUND_EN
      return (p + (1 << (F - 1))) / (1 << F);
`else
      return p / (1 << F);
`endif
   endfunction

   function automatic logic [VW-1:0] expect_vec(logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < int'(N); i++)
         r[i*W +: W] = W'(model(int'(v[i*W +: W])));
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      for (int i = 0; i < int'(N); i++)
         r[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 511))
                                                    : W'($urandom_range(0, 300));
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; start is sampled at the following edge E0
   task automatic launch(input logic [VW-1:0] v);
      start       = 1'b1;
      activations = v;
      @(posedge clk);
      @(negedge clk);
      start       = 1'b0;
      activations = rand_vec();
      check("busy_after_e0", 64'(busy), 64'(1));
      check("valid_after_e0", 64'(valid), 64'(0));
   endtask

   // Follows edges E1..E(N+1); extra[k] drives a stray start sampled at E_k
   task automatic track(input logic [VW-1:0] v, input logic [N:0] extra);
      for (int k = 1; k <= int'(N) + 1; k++) begin
         if (k <= int'(N) && extra[k]) begin
            start       = 1'b1;
            activations = rand_vec();
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         check($sformatf("busy_e%0d", k), 64'(busy), 64'(k <= int'(N)));
         check($sformatf("valid_e%0d", k), 64'(valid), 64'(k == int'(N) + 1));
      end
      check("derivatives", 64'(derivatives), 64'(expect_vec(v)));
   endtask

   task automatic run(input logic [VW-1:0] v, input logic [N:0] extra);
      launch(v);
      track(v, extra);
   endtask

   logic [VW-1:0] v, held;

   initial begin
      rst = 1'b1; start = 1'b0; activations = '0;
      repeat (2) @(negedge clk);
      check("reset_derivatives", 64'(derivatives), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_valid", 64'(valid), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Large values wrap into the 9-bit lanes; the model sees the same bits
      v = {W'(0), W'(200), W'(400), W'(600), W'(800), W'(1000)};
      run(v, '0);
      @(posedge clk); @(negedge clk);
      check("valid_one_cycle", 64'(valid), 64'(0));
      check("hold_after_valid", 64'(derivatives), 64'(expect_vec(v)));

      v = {W'(1), W'(64), W'(128), W'(192), W'(255), W'(256)};
      run(v, '0);

      // Stray starts at E2 and E4, then a back-to-back start in the valid cycle
      v = rand_vec();
      run(v, (N+1)'((1 << 2) | (1 << 4)));
      v = {N{W'(128)}};
      run(v, '0);
      held = expect_vec(v);
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         check("idle_no_valid", 64'(valid), 64'(0));
         check("idle_hold", 64'(derivatives), 64'(held));
      end

      // Asynchronous abort in the middle of the cycle after E3
      launch(rand_vec());
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_derivatives", 64'(derivatives), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_valid", 64'(valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); @(negedge clk);
         check("no_valid_after_abort", 64'(valid), 64'(0));
      end
      v = rand_vec();
      run(v, '0);

      // Random vectors, random stray starts, random idle gaps or back-to-back
      for (int r = 0; r < 20; r++) begin
         v = rand_vec();
         run(v, (N+1)'($urandom) & {{N{1'b1}}, 1'b0});
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check("rand_idle_valid", 64'(valid), 64'(0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
